// File: rtl/apb_ic_master_mux.sv
// apb_ic_master_mux
//   Sits between a set of APB masters and a single downstream APB master port. The raw PSEL
//   vector is forwarded to the arbiter as reqs. The one-hot grant from the arbiter is
//   consumed in IDLE only. The granted master is latched as owner for the whole transfer, and
//   its request is replayed downstream as a SETUP + ACCESS sequence. The completion (or a
//   forced timeout error) is routed back to the owner alone.
//
// Ports
//   clk, reset                     rising-edge clock, synchronous active-high reset
//   S_PSEL/S_PENABLE/S_PWRITE      per-master APB controls (one bit per master)
//   S_PADDR/S_PWDATA               flattened per-master address / write data
//   S_PRDATA                       shared read data, valid only alongside an S_PREADY bit
//   S_PREADY/S_PSLVERR             one-hot completion pulse and error flag to the owner
//   reqs/grants                    request vector to / one-hot grant from the arbiter
//   M_PSEL..M_PWDATA               downstream APB request
//   M_PRDATA/M_PREADY/M_PSLVERR    downstream APB response
module apb_ic_master_mux #(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_MASTERS-1:0]            S_PSEL,
    input  logic [NUM_MASTERS-1:0]            S_PENABLE,
    input  logic [NUM_MASTERS-1:0]            S_PWRITE,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] S_PADDR,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] S_PWDATA,
    output logic [DATA_WIDTH-1:0]             S_PRDATA,
    output logic [NUM_MASTERS-1:0]            S_PREADY,
    output logic [NUM_MASTERS-1:0]            S_PSLVERR,
    output logic [NUM_MASTERS-1:0]            reqs,
    input  logic [NUM_MASTERS-1:0]            grants,
    output logic                              M_PSEL,
    output logic                              M_PENABLE,
    output logic                              M_PWRITE,
    output logic [ADDR_WIDTH-1:0]             M_PADDR,
    output logic [DATA_WIDTH-1:0]             M_PWDATA,
    input  logic [DATA_WIDTH-1:0]             M_PRDATA,
    input  logic                              M_PREADY,
    input  logic                              M_PSLVERR
);

    localparam int unsigned OW = $clog2(NUM_MASTERS);
    // Counter only needs to reach TIMEOUT-1.
    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

    state_e state_q, state_d;

    logic [OW-1:0]          owner_q, owner_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   m_psel_q, m_psel_d;
    logic                   m_penable_q, m_penable_d;
    logic                   m_pwrite_q, m_pwrite_d;
    logic [ADDR_WIDTH-1:0]  m_paddr_q, m_paddr_d;
    logic [DATA_WIDTH-1:0]  m_pwdata_q, m_pwdata_d;
    logic [DATA_WIDTH-1:0]  s_prdata_q, s_prdata_d;
    logic [NUM_MASTERS-1:0] s_pready_q, s_pready_d;
    logic [NUM_MASTERS-1:0] s_pslverr_q, s_pslverr_d;

    logic [NUM_MASTERS-1:0] hit;
    logic                   hit_any;
    logic [OW-1:0]          hit_idx;
    logic                   hit_write;
    logic [ADDR_WIDTH-1:0]  hit_addr;
    logic [DATA_WIDTH-1:0]  hit_wdata;
    logic [NUM_MASTERS-1:0] owner_oh;
    logic                   expire;

    // PENABLE is not checked; masters are trusted to follow setup/access order.
    logic unused_penable;
    assign unused_penable = ^S_PENABLE;

    assign reqs = S_PSEL;
    assign hit  = S_PSEL & grants;
    assign hit_any = |hit;

    // Lowest set bit of hit wins, so a malformed multi-bit grant still picks one master.
    always_comb begin
        hit_idx   = '0;
        hit_write = 1'b0;
        hit_addr  = '0;
        hit_wdata = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                hit_idx   = OW'(i);
                hit_write = S_PWRITE[i];
                hit_addr  = S_PADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
                hit_wdata = S_PWDATA[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign owner_oh = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << owner_q;
    assign expire   = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (hit_any) state_d = StSetup;
            StSetup:  state_d = StAccess;
            StAccess: if (M_PREADY || expire) state_d = StResp;
            StResp:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Next values of the registered outputs and datapath
    always_comb begin
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        m_psel_d    = m_psel_q;
        m_penable_d = m_penable_q;
        m_pwrite_d  = m_pwrite_q;
        m_paddr_d   = m_paddr_q;
        m_pwdata_d  = m_pwdata_q;
        s_prdata_d  = s_prdata_q;
        s_pready_d  = s_pready_q;
        s_pslverr_d = s_pslverr_q;
        unique case (state_q)
            StIdle: begin
                // Owner inputs are captured here once and never re-sampled.
                if (hit_any) begin
                    owner_d    = hit_idx;
                    m_pwrite_d = hit_write;
                    m_paddr_d  = hit_addr;
                    m_pwdata_d = hit_wdata;
                    m_psel_d   = 1'b1;
                end
            end
            StSetup: begin
                m_penable_d = 1'b1;
            end
            StAccess: begin
                cnt_d = cnt_q + 1'b1;
                if (M_PREADY) begin
                    s_prdata_d  = M_PRDATA;
                    s_pslverr_d = M_PSLVERR ? owner_oh : '0;
                    s_pready_d  = owner_oh;
                    m_psel_d    = 1'b0;
                    m_penable_d = 1'b0;
                end else if (expire) begin
                    // Abandon the slave and answer the owner with an error.
                    s_prdata_d  = '0;
                    s_pslverr_d = owner_oh;
                    s_pready_d  = owner_oh;
                    m_psel_d    = 1'b0;
                    m_penable_d = 1'b0;
                end
            end
            StResp: begin
                s_pready_d  = '0;
                s_pslverr_d = '0;
                cnt_d       = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q     <= '0;
            cnt_q       <= '0;
            m_psel_q    <= 1'b0;
            m_penable_q <= 1'b0;
            m_pwrite_q  <= 1'b0;
            m_paddr_q   <= '0;
            m_pwdata_q  <= '0;
            s_prdata_q  <= '0;
            s_pready_q  <= '0;
            s_pslverr_q <= '0;
        end else begin
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            m_psel_q    <= m_psel_d;
            m_penable_q <= m_penable_d;
            m_pwrite_q  <= m_pwrite_d;
            m_paddr_q   <= m_paddr_d;
            m_pwdata_q  <= m_pwdata_d;
            s_prdata_q  <= s_prdata_d;
            s_pready_q  <= s_pready_d;
            s_pslverr_q <= s_pslverr_d;
        end
    end

    assign M_PSEL    = m_psel_q;
    assign M_PENABLE = m_penable_q;
    assign M_PWRITE  = m_pwrite_q;
    assign M_PADDR   = m_paddr_q;
    assign M_PWDATA  = m_pwdata_q;
    assign S_PRDATA  = s_prdata_q;
    assign S_PREADY  = s_pready_q;
    assign S_PSLVERR = s_pslverr_q;

endmodule
